// File: rtl/debouncer_rtl.sv
// debouncer_rtl: debounces synchronized input d into level, rise/fall pulses and an 8-bit press count
module debouncer_rtl #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       clear,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic [7:0] presses
);
  typedef enum logic [1:0] {LO, PEND_HI, HI, PEND_LO} state_t;
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(STABLE_CYCLES - 1);
  state_t state;
  logic [COUNT_W-1:0] cnt;
  logic done, inc;
  always_comb begin
    done = cnt == LAST;
    inc = state == PEND_HI && d && done;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LO;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      presses <= 8'd0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      presses <= (clear ? 8'd0 : presses) + 8'(inc);
      case (state)
        LO: begin
          state <= d ? PEND_HI : LO;
          cnt <= d ? COUNT_W'(1) : '0;
        end
        PEND_HI: begin
          state <= !d ? LO : done ? HI : PEND_HI;
          cnt <= (!d || done) ? '0 : cnt + COUNT_W'(1);
          level <= inc;
          rise <= inc;
        end
        HI: begin
          state <= !d ? PEND_LO : HI;
          cnt <= !d ? COUNT_W'(1) : '0;
        end
        default: begin
          state <= d ? HI : done ? LO : PEND_LO;
          cnt <= (d || done) ? '0 : cnt + COUNT_W'(1);
          level <= d || !done;
          fall <= !d && done;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_debouncer_rtl.sv
// tb_debouncer_rtl: randomized and directed checks of debouncer_rtl against a run-length reference model
module tb_debouncer_rtl;
  localparam int S = 4;
  logic clk, rst, d, clear;
  logic level, rise, fall;
  logic [7:0] presses;
  int tests, fails;
  logic m_level, m_rise, m_fall;
  logic [7:0] m_pr;
  int run;
  debouncer_rtl #(.STABLE_CYCLES(S), .COUNT_W(3)) dut (
    .clk(clk), .rst(rst), .d(d), .clear(clear),
    .level(level), .rise(rise), .fall(fall), .presses(presses)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".level"}, 8'(level), 8'(m_level));
    chk({tag, ".rise"}, 8'(rise), 8'(m_rise));
    chk({tag, ".fall"}, 8'(fall), 8'(m_fall));
    chk({tag, ".presses"}, presses, m_pr);
    chk({tag, ".excl"}, 8'(rise & fall), 8'd0);
  endtask
  task automatic model_reset();
    m_level = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_pr = 8'd0;
    run = 0;
  endtask
  task automatic tick(input logic dv, input logic cv, input string tag);
    d = dv;
    clear = cv;
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (cv) m_pr = 8'd0;
    if (dv != m_level) begin
      run++;
      if (run == S) begin
        run = 0;
        m_level = dv;
        if (dv) begin
          m_rise = 1'b1;
          m_pr = m_pr + 8'd1;
        end else m_fall = 1'b1;
      end
    end else run = 0;
    #1;
    check_all(tag);
  endtask
  task automatic hold(input logic dv, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(dv, 1'b0, tag);
  endtask
  initial begin
    logic [7:0] pat;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    d = 1'b1;
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 6, "clean_press");
    chk("press_presses", presses, 8'd1);
    hold(1'b0, 6, "release");
    chk("release_presses", presses, 8'd1);
    pat = 8'b0111_0111;
    for (int i = 7; i >= 0; i--) tick(pat[i], 1'b0, "glitch_lo");
    chk("glitch_lo_level", 8'(level), 8'd0);
    hold(1'b1, 5, "to_hi");
    for (int i = 7; i >= 0; i--) tick(~pat[i], 1'b0, "glitch_hi");
    chk("glitch_hi_level", 8'(level), 8'd1);
    hold(1'b0, 5, "to_lo");
    tick(1'b0, 1'b1, "clear_idle");
    chk("clear_idle_presses", presses, 8'd0);
    hold(1'b1, 3, "clear_rise_pend");
    tick(1'b1, 1'b1, "clear_rise");
    chk("clear_rise_presses", presses, 8'd1);
    hold(1'b0, 5, "clear_rise_rel");
    tick(1'b0, 1'b1, "clear_again");
    for (int i = 0; i < 256; i++) begin
      hold(1'b1, $urandom_range(S, S + 2), "wrap_press");
      hold(1'b0, $urandom_range(S, S + 2), "wrap_release");
    end
    chk("wrap_presses", presses, 8'd0);
    for (int i = 0; i < 600; i++) begin
      logic dv;
      int len;
      dv = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * S);
      for (int j = 0; j < len; j++) tick(dv, $urandom_range(0, 31) == 0, "random");
    end
    hold(1'b0, S + 1, "pre_async");
    hold(1'b1, 3, "async_pend");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_immediate");
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 3, "async_after");
    chk("async_after_level", 8'(level), 8'd0);
    tick(1'b1, 1'b0, "async_accept");
    chk("async_accept_level", 8'(level), 8'd1);
    hold(1'b1, 3, "high_pulse");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_from_hi");
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, S + 1, "final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debouncer_rtl.md
# debouncer_rtl

Debounces a single-bit board input (push button or switch) after it leaves the two-flop synchronizer, and presents a clean level, one-cycle rise/fall pulses, and an 8-bit press counter. It sits directly downstream of the synchronizer, between the board I/O and the TinyRV1 processor's memory-mapped input ports. Its input `d` is the synchronizer output `q` and is already in the `clk` domain.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive rising edges `d` must hold a new value before it is accepted; legal range 2 ≤ `STABLE_CYCLES` ≤ 2^`COUNT_W`.
- `COUNT_W`, default 3: width of the internal stability counter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low; while 0, all state is held at its reset value.
- `d`  in  1  synchronized raw input from the synchronizer.
- `clear`  in  1  synchronous clear of `presses`.
- `level`  out  1  debounced level.
- `rise`  out  1  one-cycle pulse when `level` goes 0→1.
- `fall`  out  1  one-cycle pulse when `level` goes 1→0.
- `presses`  out  8  count of accepted rising transitions, modulo 256.

## Operation
- FSM states:
  - `LO`: stable low.
  - `PEND_HI`: candidate high.
  - `HI`: stable high.
  - `PEND_LO`: candidate low.
- Stability counter `cnt` is `COUNT_W` bits wide. All outputs are registered.
- `LO`: if `d`=1, go to `PEND_HI` and set `cnt`←1. Otherwise stay in `LO` with `cnt`←0.
- `PEND_HI`:
  - `d`=0: return to `LO`, `cnt`←0 (glitch rejected, no output change).
  - `d`=1 and `cnt` = `STABLE_CYCLES`−1: go to `HI`, `level`←1, `rise`←1, `presses`←`presses`+1, `cnt`←0.
  - `d`=1 otherwise: `cnt`←`cnt`+1.
- `HI` and `PEND_LO` mirror `LO` and `PEND_HI` with `d` inverted. On acceptance: go to `LO`, `level`←0, `fall`←1. `presses` is unchanged.
- `rise` and `fall` are 1 only in the cycle after the accepting edge. Each returns to 0 on the next edge. They are never both 1 in the same cycle.
- `presses` wraps 255→0 on increment; no saturation.
- `clear`:
  - `clear`=1 with no increment: `presses`←0.
  - `clear`=1 on the same edge as an accepted rise: `presses`←1 (the clear applies first, then the increment).
  - `clear` has no effect on the FSM, `level`, or pulses.

## Timing
- Reset values (immediate on `rst` falling, independent of `clk`):
  - state=`LO`, `cnt`=0
  - `level`=0, `rise`=0, `fall`=0, `presses`=0
- Reset asserted mid-operation (any state, including `PEND_*`, or during a pulse) aborts everything. After `rst` returns to 1, the block behaves as freshly reset and needs a full `STABLE_CYCLES` run of 1s to raise `level`.
- Latency: if `d` goes 0→1 before edge k and is held, edges k … k+`STABLE_CYCLES`−1 sample 1. `level` and `rise` go to 1 immediately after edge k+`STABLE_CYCLES`−1. Including the upstream synchronizer, pin-to-`level` latency is `STABLE_CYCLES`+2 cycles.
- A glitch shorter than `STABLE_CYCLES` sampled edges produces no change on any output.
- A `d` toggle on the same edge that would complete acceptance is evaluated with the new sample: `d`=0 in `PEND_HI` at `cnt`=`STABLE_CYCLES`−1 rejects.
- X on `d` outside reset is not handled; the upstream block guarantees known values after its two-cycle fill.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `COUNT_W`=3.
- Reset: hold `rst`=0 for 2 cycles with `d`=1 → `level`=0, `rise`=0, `fall`=0, `presses`=0 throughout; `level` stays 0 for the first 3 cycles after release.
- Clean press: `d`=1 held for 6 cycles from reset → `level`=0 after edges 1–3; after edge 4, `level`=1, `rise`=1, `presses`=1; after edge 5, `rise`=0, `level`=1.
- Glitch reject: `d`=1,1,1,0,1,1,1,0 → `level` stays 0, `rise` never 1, `presses`=0. Repeat the same pattern from `HI` with `d`=0 bursts → `level` stays 1, `fall` never 1.
- Release: from `HI`, `d`=0 held → after the 4th sampled 0, `level`=0 and `fall`=1 for exactly 1 cycle; `presses` is unchanged.
- Counter:
  - 256 clean press/release pairs → `presses` returns to 0 (wrap).
  - `clear`=1 on the edge that accepts a rise → `presses`=1.
  - `clear`=1 while idle → `presses`=0.
- Async reset mid-pending: `d`=1 for 3 edges, then `rst`=0 between edges → state clears immediately; after release with `d`=1 held, `level` rises only after 4 further edges.
